// File: rtl/guess_entry.sv
// Keystroke accumulator and round controller for the word game: builds a 6-letter guess,
// submits it to the comparator, counts attempts and declares win/lose. Optional: GUESS_ENTRY_HARD_MODE_EN.
module guess_entry #(
    parameter int unsigned MAX_GUESSES = 6,
    parameter logic [7:0]  BLANK       = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    input  logic        key_bksp,
    input  logic        key_enter,
    input  logic        restart,
    input  logic [5:0]  in_place,
    output logic [47:0] guessed,
    output logic        guess_strobe,
    output logic [2:0]  pos,
    output logic [2:0]  attempts,
    output logic        reject,
    output logic        win,
    output logic        lose
);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_SUBMIT,
        ST_WIN,
        ST_LOSE
    } state_t;

    localparam logic [2:0] MAX_ATT = 3'(MAX_GUESSES);

    state_t     state_q, state_d;
    logic [7:0] slot_q [6];
    logic [7:0] slot_d [6];
    logic [2:0] pos_q, pos_d;
    logic [2:0] attempts_q, attempts_d;
    logic       reject_q, reject_d;
    logic       hard_ok;
    logic [2:0] attempts_inc;

    assign attempts_inc = 3'(attempts_q + 3'd1);

`ifdef GUESS_ENTRY_HARD_MODE_EN
    // Letters confirmed green on the previous submit must be kept in place.
    logic [5:0] hard_place_q, hard_place_d;
    logic [7:0] hard_slot_q [6];
    logic [7:0] hard_slot_d [6];
    logic [5:0] slot_ok;

    for (genvar gi = 0; gi < 6; gi++) begin : g_hard
        assign slot_ok[gi] = !hard_place_q[5-gi] || (hard_slot_q[gi] == slot_q[gi]);
    end
    assign hard_ok = &slot_ok;
`else
    assign hard_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        attempts_d = attempts_q;
        reject_d   = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slot_d[i] = slot_q[i];
        end
`ifdef GUESS_ENTRY_HARD_MODE_EN
        hard_place_d = hard_place_q;
        for (int i = 0; i < 6; i++) begin
            hard_slot_d[i] = hard_slot_q[i];
        end
`endif

        if (restart) begin
            state_d    = ST_ENTRY;
            pos_d      = 3'd0;
            attempts_d = 3'd0;
            for (int i = 0; i < 6; i++) begin
                slot_d[i] = BLANK;
            end
`ifdef GUESS_ENTRY_HARD_MODE_EN
            hard_place_d = 6'd0;
            for (int i = 0; i < 6; i++) begin
                hard_slot_d[i] = BLANK;
            end
`endif
        end else begin
            case (state_q)
                ST_ENTRY: begin
                    if (key_enter) begin
                        if (pos_q == 3'd6 && hard_ok) begin
                            state_d = ST_SUBMIT;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (key_bksp) begin
                        if (pos_q != 3'd0) begin
                            pos_d = 3'(pos_q - 3'd1);
                            for (int i = 0; i < 6; i++) begin
                                if (pos_q == 3'(i + 1)) slot_d[i] = BLANK;
                            end
                        end else begin
                            reject_d = 1'b1;
                        end
                    end else if (key_valid) begin
                        if (pos_q < 3'd6 && key_code <= 5'd25) begin
                            pos_d = 3'(pos_q + 3'd1);
                            for (int i = 0; i < 6; i++) begin
                                if (pos_q == 3'(i)) slot_d[i] = 8'h61 + {3'b000, key_code};
                            end
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                end
                ST_SUBMIT: begin
                    // Keys arriving now are dropped without reject.
                    attempts_d = attempts_inc;
`ifdef GUESS_ENTRY_HARD_MODE_EN
                    hard_place_d = in_place;
                    for (int i = 0; i < 6; i++) begin
                        hard_slot_d[i] = slot_q[i];
                    end
`endif
                    if (in_place == 6'b111111) begin
                        state_d = ST_WIN;
                    end else if (attempts_inc == MAX_ATT) begin
                        state_d = ST_LOSE;
                    end else begin
                        state_d = ST_ENTRY;
                        pos_d   = 3'd0;
                        for (int i = 0; i < 6; i++) begin
                            slot_d[i] = BLANK;
                        end
                    end
                end
                default: begin
                    reject_d = key_valid | key_bksp | key_enter;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_ENTRY;
            pos_q      <= 3'd0;
            attempts_q <= 3'd0;
            reject_q   <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= BLANK;
            end
`ifdef GUESS_ENTRY_HARD_MODE_EN
            hard_place_q <= 6'd0;
            for (int i = 0; i < 6; i++) begin
                hard_slot_q[i] <= BLANK;
            end
`endif
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            attempts_q <= attempts_d;
            reject_q   <= reject_d;
            for (int i = 0; i < 6; i++) begin
                slot_q[i] <= slot_d[i];
            end
`ifdef GUESS_ENTRY_HARD_MODE_EN
            hard_place_q <= hard_place_d;
            for (int i = 0; i < 6; i++) begin
                hard_slot_q[i] <= hard_slot_d[i];
            end
`endif
        end
    end

    for (genvar gi = 0; gi < 6; gi++) begin : g_pack
        assign guessed[47-8*gi -: 8] = slot_q[gi];
    end

    assign guess_strobe = (state_q == ST_SUBMIT);
    assign pos          = pos_q;
    assign attempts     = attempts_q;
    assign reject       = reject_q;
    assign win          = (state_q == ST_WIN);
    assign lose         = (state_q == ST_LOSE);

endmodule

// File: tb/tb_guess_entry.sv
// Directed bench for guess_entry; a small positional-compare model against "design" stands in for wordcmp.
module tb_guess_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = 5'd0;
    logic        key_bksp = 1'b0;
    logic        key_enter = 1'b0;
    logic        restart = 1'b0;
    logic [5:0]  in_place;
    logic [47:0] guessed;
    logic        guess_strobe;
    logic [2:0]  pos;
    logic [2:0]  attempts;
    logic        reject;
    logic        win;
    logic        lose;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [47:0] TARGET = "design";
    localparam logic [47:0] BLANKS = "      ";

    always #5 clk = ~clk;

    guess_entry #(.MAX_GUESSES(6), .BLANK(8'h20)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_valid(key_valid), .key_code(key_code), .key_bksp(key_bksp),
        .key_enter(key_enter), .restart(restart), .in_place(in_place),
        .guessed(guessed), .guess_strobe(guess_strobe), .pos(pos),
        .attempts(attempts), .reject(reject), .win(win), .lose(lose)
    );

    always_comb begin
        in_place = 6'd0;
        for (int i = 0; i < 6; i++) begin
            in_place[5-i] = (guessed[47-8*i -: 8] == TARGET[47-8*i -: 8]);
        end
    end

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One strobe set for one clock edge; outputs are settled 1 ns after the edge.
    task automatic key(input logic v, input logic b, input logic e, input logic r, input logic [4:0] code);
        @(negedge clk);
        key_valid = v; key_bksp = b; key_enter = e; restart = r; key_code = code;
        @(posedge clk);
        #1;
        key_valid = 1'b0; key_bksp = 1'b0; key_enter = 1'b0; restart = 1'b0; key_code = 5'd0;
        $display("key v=%b b=%b e=%b r=%b code=%0d -> guessed=\"%s\" pos=%0d att=%0d rej=%b gs=%b win=%b lose=%b",
                 v, b, e, r, code, guessed, pos, attempts, reject, guess_strobe, win, lose);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic type_word(input logic [47:0] w);
        logic [7:0] c;
        for (int i = 0; i < 6; i++) begin
            c = w[47-8*i -: 8];
            key(1'b1, 1'b0, 1'b0, 1'b0, 5'(c - 8'h61));
        end
    endtask

    task automatic submit_word(input logic [47:0] w);
        type_word(w);
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        idle();
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_guessed", guessed, BLANKS);
        check("rst_pos", 48'(pos), 48'd0);
        check("rst_attempts", 48'(attempts), 48'd0);
        check("rst_flags", 48'({reject, guess_strobe, win, lose}), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Winning guess
        type_word("design");
        check("win_pos", 48'(pos), 48'd6);
        check("win_guessed", guessed, "design");
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("win_strobe", 48'(guess_strobe), 48'd1);
        check("win_no_reject", 48'(reject), 48'd0);
        idle();
        check("win_level", 48'({win, lose, guess_strobe}), 48'b100);
        check("win_attempts", 48'(attempts), 48'd1);
        check("win_hold", guessed, "design");
        key(1'b1, 1'b0, 1'b0, 1'b0, 5'd3);
        check("win_key_reject", 48'(reject), 48'd1);
        idle();
        check("reject_pulse", 48'(reject), 48'd0);
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("win_enter_reject", 48'({reject, win}), 48'b11);

        // Restart together with a key: key ignored, no reject
        key(1'b1, 1'b0, 1'b0, 1'b1, 5'd0);
        check("restart_state", 48'({win, lose, reject}), 48'd0);
        check("restart_attempts", 48'(attempts), 48'd0);
        check("restart_pos", 48'(pos), 48'd0);
        check("restart_guessed", guessed, BLANKS);

        // Two wrong guesses
        submit_word("desert");
        check("g1_pos", 48'(pos), 48'd0);
        check("g1_guessed", guessed, BLANKS);
        check("g1_attempts", 48'(attempts), 48'd1);
        check("g1_wl", 48'({win, lose}), 48'd0);
        submit_word("dampen");
        check("g2_pos", 48'(pos), 48'd0);
        check("g2_guessed", guessed, BLANKS);
        check("g2_attempts", 48'(attempts), 48'd2);
        check("g2_wl", 48'({win, lose}), 48'd0);

        // Boundary keys
        key(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        key(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        check("bksp_pos0_reject", 48'(reject), 48'd1);
        type_word("abacuz");
        key(1'b1, 1'b0, 1'b0, 1'b0, 5'd23);
        check("seventh_reject", 48'(reject), 48'd1);
        check("seventh_guessed", guessed, "abacuz");
        key(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        check("bksp_pos", 48'(pos), 48'd5);
        check("bksp_guessed", guessed, "abacu ");
        check("bksp_no_reject", 48'(reject), 48'd0);
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("enter_pos5_reject", 48'({reject, guess_strobe}), 48'b10);
        key(1'b1, 1'b0, 1'b0, 1'b0, 5'd26);
        check("code26_reject", 48'(reject), 48'd1);
        check("code26_pos", 48'(pos), 48'd5);
        key(1'b1, 1'b0, 1'b0, 1'b0, 5'd18);
        check("abacus", guessed, "abacus");
        check("abacus_pos", 48'(pos), 48'd6);

        // Six wrong guesses lose
        key(1'b0, 1'b0, 0, 1'b1, 5'd0);
        for (int n = 1; n <= 5; n++) submit_word("useful");
        check("lose5_state", 48'({lose, attempts}), 48'({1'b0, 3'd5}));
        submit_word("useful");
        check("lose6_lose", 48'(lose), 48'd1);
        check("lose6_attempts", 48'(attempts), 48'd6);
        check("lose6_hold", guessed, "useful");
        idle();
        check("lose6_no_wrap", 48'(attempts), 48'd6);
        key(1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        check("lose_restart", 48'({lose, attempts}), 48'd0);

        // Enter + letter at pos 6, then async reset mid-SUBMIT
        submit_word("desert");
        type_word("dampen");
        key(1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        check("simul_strobe", 48'({guess_strobe, reject}), 48'b10);
        check("simul_guessed", guessed, "dampen");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_guessed", guessed, BLANKS);
        check("async_attempts", 48'(attempts), 48'd0);
        check("async_flags", 48'({pos, guess_strobe, reject, win, lose}), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef GUESS_ENTRY_HARD_MODE_EN
        submit_word("desert");
        type_word("abacus");
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("hard_reject", 48'({reject, guess_strobe}), 48'b10);
        check("hard_pos", 48'(pos), 48'd6);
        for (int n = 0; n < 6; n++) key(1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        type_word("desist");
        key(1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        check("hard_accept", 48'({reject, guess_strobe}), 48'b01);
        idle();
        check("hard_attempts", 48'(attempts), 48'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
